lieat_exu_dmem_arbiter: RTL and testbench

- Shares one data-memory request/response port between the scalar LSU (requester 0) and the vector VLSU (requester 1).
- Arbitrates requests round-robin, with a lock that lets the VLSU hold the port for a whole multi-beat vector access.
- Records the owner of every accepted request in an in-order outstanding FIFO and steers each response back to that owner.
- Sits between the EXU load/store units and the dmem bus/bridge.

---
 rtl/lieat_exu_dmem_arbiter_if.sv | 34 +++
 rtl/lieat_exu_dmem_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_lieat_exu_dmem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lieat_exu_dmem_arbiter_if.sv
// Data-memory request/response channel shared by the LSU, the VLSU and the
// dmem bus. The master side issues requests and accepts responses. The slave
// side accepts requests and returns responses.
interface lieat_exu_dmem_arbiter_if #(
  parameter int XLEN = 32
);

  // Request channel
  logic            req_valid;
  logic            req_ready;
  logic            req_ren;
  logic            req_wen;
  logic [XLEN-1:0] req_addr;
  logic [2:0]      req_flag;
  logic [XLEN-1:0] req_wdata;

  // Response channel
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rdata;

  modport master (
    output req_valid, req_ren, req_wen, req_addr, req_flag, req_wdata,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_ren, req_wen, req_addr, req_flag, req_wdata,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/lieat_exu_dmem_arbiter.sv
// Data-memory port arbiter between the scalar LSU (s0) and the vector VLSU
// (s1).
// - Requests are arbitrated round-robin, and the VLSU can lock the port for
//   the whole of a multi-beat access.
// - A request that is offered but stalled keeps its owner until it is
//   accepted.
// - The owner of every accepted request is queued in an in-order FIFO, and
//   each response goes back to the owner at the FIFO head.
module lieat_exu_dmem_arbiter #(
  parameter  int XLEN      = 32,
  parameter  int OST_DEPTH = 2,
  localparam int PTR_W     = $clog2(OST_DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic                           clock,
  input  logic                           reset,          // async, active-low
  lieat_exu_dmem_arbiter_if.slave        s0,             // scalar LSU
  lieat_exu_dmem_arbiter_if.slave        s1,             // vector VLSU
  input  logic                           s1_lock,
  lieat_exu_dmem_arbiter_if.master       m,              // dmem bus side
  output logic [CNT_W-1:0]               ost_cnt,
  output logic                           err_rsp_orphan
);

  typedef enum logic {
    OWNER_S0 = 1'b0,
    OWNER_S1 = 1'b1
  } owner_e;

  // The FIFO pointers wrap by natural overflow, so the depth must be a power of two.
  if (OST_DEPTH < 2 || (OST_DEPTH & (OST_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("lieat_exu_dmem_arbiter: OST_DEPTH must be a power of two >= 2");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] ost_cnt_q,     ost_cnt_d;
  logic [PTR_W-1:0] wr_ptr_q,      wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,      rd_ptr_d;
  logic             hold_q,        hold_d;
  owner_e           hold_owner_q,  hold_owner_d;
  owner_e           last_grant_q,  last_grant_d;
  logic             err_q,         err_d;
  owner_e           ost_fifo_q [OST_DEPTH];

  // ---------------------------------------------------------------------------
  // Derived status
  // ---------------------------------------------------------------------------
  logic   full;
  logic   empty;
  owner_e grant;
  owner_e head;
  logic   req_fire;
  logic   rsp_fire;

  assign full  = (ost_cnt_q == CNT_W'(OST_DEPTH));
  assign empty = (ost_cnt_q == '0);
  assign head  = ost_fifo_q[rd_ptr_q];

  // Grant select: a stalled request keeps its owner first, then the VLSU lock, then round-robin.
  always_comb begin
    // NOTE: give every always_comb output a default before any branch so that
    // no path leaves it unassigned; an unassigned path infers a latch.
    grant = OWNER_S0;
    if (hold_q) begin
      grant = hold_owner_q;
    end else if (s1_lock && last_grant_q == OWNER_S1) begin
      grant = OWNER_S1;
    end else if (s0.req_valid && !s1.req_valid) begin
      grant = OWNER_S0;
    end else if (!s0.req_valid && s1.req_valid) begin
      grant = OWNER_S1;
    end else if (s0.req_valid && s1.req_valid) begin
      grant = (last_grant_q == OWNER_S1) ? OWNER_S0 : OWNER_S1;
    end
  end

  // Request mux: the granted requester drives the bus, and a full FIFO blocks issue.
  always_comb begin
    m.req_valid  = 1'b0;
    m.req_ren    = s0.req_ren;
    m.req_wen    = s0.req_wen;
    m.req_addr   = s0.req_addr;
    m.req_flag   = s0.req_flag;
    m.req_wdata  = s0.req_wdata;
    s0.req_ready = 1'b0;
    s1.req_ready = 1'b0;
    if (grant == OWNER_S1) begin
      m.req_valid  = s1.req_valid & ~full;
      m.req_ren    = s1.req_ren;
      m.req_wen    = s1.req_wen;
      m.req_addr   = s1.req_addr;
      m.req_flag   = s1.req_flag;
      m.req_wdata  = s1.req_wdata;
      s1.req_ready = m.req_ready & ~full;
    end else begin
      m.req_valid  = s0.req_valid & ~full;
      s0.req_ready = m.req_ready & ~full;
    end
  end

  assign req_fire = m.req_valid & m.req_ready;

  // Response steering: the FIFO head names the owner; nothing is accepted while the FIFO is empty.
  always_comb begin
    s0.rsp_valid = 1'b0;
    s1.rsp_valid = 1'b0;
    m.rsp_ready  = 1'b0;
    if (!empty) begin
      if (head == OWNER_S1) begin
        s1.rsp_valid = m.rsp_valid;
        m.rsp_ready  = s1.rsp_ready;
      end else begin
        s0.rsp_valid = m.rsp_valid;
        m.rsp_ready  = s0.rsp_ready;
      end
    end
  end

  assign s0.rsp_rdata = m.rsp_rdata;
  assign s1.rsp_rdata = m.rsp_rdata;
  assign rsp_fire     = m.rsp_valid & m.rsp_ready;

  // Next state: the hold/last-grant tracking, the outstanding count, the pointers and the orphan flag.
  always_comb begin
    hold_d       = hold_q;
    hold_owner_d = hold_owner_q;
    last_grant_d = last_grant_q;
    ost_cnt_d    = ost_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    err_d        = err_q;

    if (req_fire) begin
      hold_d       = 1'b0;
      last_grant_d = grant;
      wr_ptr_d     = wr_ptr_q + PTR_W'(1);
    end else if (m.req_valid && !m.req_ready) begin
      hold_d       = 1'b1;
      hold_owner_d = grant;
    end

    if (rsp_fire) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({req_fire, rsp_fire})
      2'b10:   ost_cnt_d = ost_cnt_q + CNT_W'(1);
      2'b01:   ost_cnt_d = ost_cnt_q - CNT_W'(1);
      default: ost_cnt_d = ost_cnt_q;
    endcase

    if (m.rsp_valid && empty) begin
      err_d = 1'b1;
    end
  end

  // Control registers, cleared asynchronously on reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so that every
      // register samples the values from before the clock edge.
      hold_q       <= 1'b0;
      hold_owner_q <= OWNER_S0;
      last_grant_q <= OWNER_S1;
      ost_cnt_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      hold_owner_q <= hold_owner_d;
      last_grant_q <= last_grant_d;
      ost_cnt_q    <= ost_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      err_q        <= err_d;
    end
  end

  // Owner FIFO storage: one entry is written per accepted request.
  always_ff @(posedge clock) begin
    // NOTE: the storage array has no reset. The count and the pointers are
    // reset, and an entry is read only after it has been written.
    if (req_fire) begin
      ost_fifo_q[wr_ptr_q] <= grant;
    end
  end

  assign ost_cnt        = ost_cnt_q;
  assign err_rsp_orphan = err_q;

endmodule

// File: tb/tb_lieat_exu_dmem_arbiter.sv
// Directed bench for lieat_exu_dmem_arbiter. Inputs change 1 ns after a
// rising edge, and outputs are checked 1 ns later, well before the next edge.
module tb_lieat_exu_dmem_arbiter;

  localparam int XLEN      = 32;
  localparam int OST_DEPTH = 2;
  localparam int CNT_W     = $clog2(OST_DEPTH) + 1;

  logic             clock;
  logic             reset;
  logic             s1_lock;
  logic [CNT_W-1:0] ost_cnt;
  logic             err_rsp_orphan;

  int vectors;
  int miscompares;

  lieat_exu_dmem_arbiter_if #(.XLEN(XLEN)) s0_if ();
  lieat_exu_dmem_arbiter_if #(.XLEN(XLEN)) s1_if ();
  lieat_exu_dmem_arbiter_if #(.XLEN(XLEN)) m_if  ();

  lieat_exu_dmem_arbiter #(
    .XLEN      (XLEN),
    .OST_DEPTH (OST_DEPTH)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .s0             (s0_if.slave),
    .s1             (s1_if.slave),
    .s1_lock        (s1_lock),
    .m              (m_if.master),
    .ost_cnt        (ost_cnt),
    .err_rsp_orphan (err_rsp_orphan)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    s1_lock     = 1'b0;
    s0_if.req_valid = 0; s0_if.req_ren = 0; s0_if.req_wen = 0;
    s0_if.req_addr  = 0; s0_if.req_flag = 0; s0_if.req_wdata = 0;
    s0_if.rsp_ready = 0;
    s1_if.req_valid = 0; s1_if.req_ren = 0; s1_if.req_wen = 0;
    s1_if.req_addr  = 0; s1_if.req_flag = 0; s1_if.req_wdata = 0;
    s1_if.rsp_ready = 0;
    m_if.req_ready  = 0; m_if.rsp_valid = 0; m_if.rsp_rdata = 0;

    // ---- Idle after reset ----
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check("idle ost_cnt",      32'(ost_cnt), 0);
    check("idle m_req_valid",  32'(m_if.req_valid), 0);
    check("idle err",          32'(err_rsp_orphan), 0);
    check("idle s0_req_ready", 32'(s0_if.req_ready), 0);
    check("idle s1_req_ready", 32'(s1_if.req_ready), 0);
    check("idle s0_rsp_valid", 32'(s0_if.rsp_valid), 0);
    check("idle s1_rsp_valid", 32'(s1_if.rsp_valid), 0);
    check("idle m_rsp_ready",  32'(m_if.rsp_ready), 0);

    // ---- Tie round-robin; memory answers one cycle after each request ----
    s0_if.rsp_ready = 1; s1_if.rsp_ready = 1;
    s0_if.req_valid = 1; s0_if.req_addr = 32'h100; s0_if.req_ren = 1;
    s0_if.req_flag  = 3'b010; s0_if.req_wdata = 32'h1234_5678;
    s1_if.req_valid = 1; s1_if.req_addr = 32'h200; s1_if.req_wen = 1;
    s1_if.req_flag  = 3'b001; s1_if.req_wdata = 32'h0000_9ABC;
    m_if.req_ready  = 1;
    settle();
    check("rr0 addr",  m_if.req_addr, 32'h100);
    check("rr0 ren",   32'(m_if.req_ren), 1);
    check("rr0 wen",   32'(m_if.req_wen), 0);
    check("rr0 flag",  32'(m_if.req_flag), 32'h2);
    check("rr0 wdata", m_if.req_wdata, 32'h1234_5678);
    check("rr0 s0_ready", 32'(s0_if.req_ready), 1);
    check("rr0 s1_ready", 32'(s1_if.req_ready), 0);
    tick();
    m_if.rsp_valid = 1; m_if.rsp_rdata = 32'hAAAA_0000;
    settle();
    check("rr1 addr",  m_if.req_addr, 32'h200);
    check("rr1 wen",   32'(m_if.req_wen), 1);
    check("rr1 flag",  32'(m_if.req_flag), 32'h1);
    check("rr1 wdata", m_if.req_wdata, 32'h0000_9ABC);
    check("rr1 s1_ready", 32'(s1_if.req_ready), 1);
    check("rr1 s0_ready", 32'(s0_if.req_ready), 0);
    check("rr1 s0_rsp_valid", 32'(s0_if.rsp_valid), 1);
    check("rr1 s1_rsp_valid", 32'(s1_if.rsp_valid), 0);
    check("rr1 s0_rdata", s0_if.rsp_rdata, 32'hAAAA_0000);
    check("rr1 m_rsp_ready", 32'(m_if.rsp_ready), 1);
    check("rr1 ost_cnt", 32'(ost_cnt), 1);
    tick();
    m_if.rsp_rdata = 32'hBBBB_0000;
    settle();
    check("rr2 addr", m_if.req_addr, 32'h100);
    check("rr2 s1_rsp_valid", 32'(s1_if.rsp_valid), 1);
    check("rr2 s0_rsp_valid", 32'(s0_if.rsp_valid), 0);
    check("rr2 s1_rdata", s1_if.rsp_rdata, 32'hBBBB_0000);
    check("rr2 ost_cnt", 32'(ost_cnt), 1);
    tick();
    m_if.rsp_rdata = 32'hAAAA_0000;
    settle();
    check("rr3 addr", m_if.req_addr, 32'h200);
    check("rr3 s0_rsp_valid", 32'(s0_if.rsp_valid), 1);
    tick();
    s0_if.req_valid = 0; s1_if.req_valid = 0;
    s0_if.req_ren = 0; s1_if.req_wen = 0;
    m_if.rsp_rdata = 32'hBBBB_0000;
    settle();
    check("rr4 m_req_valid", 32'(m_if.req_valid), 0);
    check("rr4 s1_rsp_valid", 32'(s1_if.rsp_valid), 1);
    check("rr4 s0_rsp_valid", 32'(s0_if.rsp_valid), 0);
    tick();
    m_if.rsp_valid = 0;
    settle();
    check("rr5 ost_cnt", 32'(ost_cnt), 0);

    // ---- A single s0 transfer so that last_grant = s0 before the hold test ----
    s0_if.req_valid = 1; s0_if.req_addr = 32'h180;
    settle();
    check("pre s0_ready", 32'(s0_if.req_ready), 1);
    tick();
    s0_if.req_valid = 0;
    m_if.rsp_valid = 1; m_if.rsp_rdata = 32'h1111_2222;
    settle();
    check("pre s0_rsp_valid", 32'(s0_if.rsp_valid), 1);
    tick();
    m_if.rsp_valid = 0;

    // ---- Hold stability: a stalled s0 request keeps the port ----
    m_if.req_ready = 0;
    s0_if.req_valid = 1; s0_if.req_addr = 32'h300;
    settle();
    check("hold1 addr", m_if.req_addr, 32'h300);
    check("hold1 m_req_valid", 32'(m_if.req_valid), 1);
    check("hold1 s0_ready", 32'(s0_if.req_ready), 0);
    tick();
    s1_if.req_valid = 1; s1_if.req_addr = 32'h400;
    settle();
    check("hold2 addr", m_if.req_addr, 32'h300);
    check("hold2 s1_ready", 32'(s1_if.req_ready), 0);
    tick();
    settle();
    check("hold3 addr", m_if.req_addr, 32'h300);
    tick();
    m_if.req_ready = 1;
    settle();
    check("hold4 addr", m_if.req_addr, 32'h300);
    check("hold4 s0_ready", 32'(s0_if.req_ready), 1);
    check("hold4 s1_ready", 32'(s1_if.req_ready), 0);
    tick();
    s0_if.req_valid = 0;
    settle();
    check("hold5 addr", m_if.req_addr, 32'h400);
    check("hold5 s1_ready", 32'(s1_if.req_ready), 1);
    tick();
    s1_if.req_valid = 0; m_if.req_ready = 0;
    m_if.rsp_valid = 1; m_if.rsp_rdata = 32'h0000_00C0;
    settle();
    check("hold ost_cnt", 32'(ost_cnt), 2);
    check("hold rspA s0", 32'(s0_if.rsp_valid), 1);
    check("hold rspA s1", 32'(s1_if.rsp_valid), 0);
    tick();
    m_if.rsp_rdata = 32'h0000_00D0;
    settle();
    check("hold rspB s1", 32'(s1_if.rsp_valid), 1);
    check("hold rspB s0", 32'(s0_if.rsp_valid), 0);
    tick();
    m_if.rsp_valid = 0;

    // ---- Vector lock: four s1 beats while s0 waits ----
    s1_lock = 1; m_if.req_ready = 1;
    s0_if.req_valid = 1; s0_if.req_addr = 32'h500;
    s1_if.req_valid = 1;
    for (int i = 0; i < 4; i++) begin
      s1_if.req_addr = 32'h1000 + 32'(4 * i);
      m_if.rsp_valid = (i != 0);
      m_if.rsp_rdata = 32'hCAFE_0000 + 32'(i);
      settle();
      check($sformatf("lock%0d addr", i), m_if.req_addr, 32'h1000 + 32'(4 * i));
      check($sformatf("lock%0d s1_ready", i), 32'(s1_if.req_ready), 1);
      check($sformatf("lock%0d s0_ready", i), 32'(s0_if.req_ready), 0);
      if (i != 0) begin
        check($sformatf("lock%0d s1_rsp_valid", i), 32'(s1_if.rsp_valid), 1);
      end
      tick();
    end
    s1_lock = 0; s1_if.req_addr = 32'h1010;
    m_if.rsp_valid = 1;
    settle();
    check("unlock addr", m_if.req_addr, 32'h500);
    check("unlock s0_ready", 32'(s0_if.req_ready), 1);
    check("unlock s1_ready", 32'(s1_if.req_ready), 0);
    check("unlock s1_rsp_valid", 32'(s1_if.rsp_valid), 1);
    tick();
    s0_if.req_valid = 0; s1_if.req_valid = 0;
    settle();
    check("unlock s0_rsp_valid", 32'(s0_if.rsp_valid), 1);
    tick();
    m_if.rsp_valid = 0;
    settle();
    check("lock ost_cnt", 32'(ost_cnt), 0);

    // ---- Backpressure: the FIFO fills and a same-cycle pop does not unblock ----
    s0_if.req_valid = 1; s0_if.req_addr = 32'h600;
    settle();
    check("full0 s0_ready", 32'(s0_if.req_ready), 1);
    tick();
    s0_if.req_addr = 32'h604;
    settle();
    check("full1 s0_ready", 32'(s0_if.req_ready), 1);
    tick();
    s0_if.req_addr = 32'h608;
    settle();
    check("full2 ost_cnt", 32'(ost_cnt), 2);
    check("full2 s0_ready", 32'(s0_if.req_ready), 0);
    check("full2 m_req_valid", 32'(m_if.req_valid), 0);
    tick();
    m_if.rsp_valid = 1;
    settle();
    check("full3 s0_ready", 32'(s0_if.req_ready), 0);
    check("full3 m_rsp_ready", 32'(m_if.rsp_ready), 1);
    check("full3 s0_rsp_valid", 32'(s0_if.rsp_valid), 1);
    tick();
    m_if.rsp_valid = 0;
    settle();
    check("full4 ost_cnt", 32'(ost_cnt), 1);
    check("full4 s0_ready", 32'(s0_if.req_ready), 1);
    check("full4 addr", m_if.req_addr, 32'h608);
    tick();
    s0_if.req_valid = 0;
    m_if.rsp_valid = 1;
    settle();
    check("full5 ost_cnt", 32'(ost_cnt), 2);
    tick();
    tick();
    m_if.rsp_valid = 0;
    settle();
    check("full drained", 32'(ost_cnt), 0);

    // ---- Orphan response ----
    m_if.rsp_valid = 1;
    settle();
    check("orph m_rsp_ready", 32'(m_if.rsp_ready), 0);
    check("orph s0_rsp_valid", 32'(s0_if.rsp_valid), 0);
    check("orph s1_rsp_valid", 32'(s1_if.rsp_valid), 0);
    tick();
    m_if.rsp_valid = 0;
    settle();
    check("orph err set", 32'(err_rsp_orphan), 1);
    tick();
    check("orph err sticky", 32'(err_rsp_orphan), 1);

    // ---- Reset during a transaction; the late response becomes an orphan ----
    s0_if.req_valid = 1; s0_if.req_addr = 32'h700;
    tick();
    s0_if.req_valid = 0;
    settle();
    check("mid ost_cnt", 32'(ost_cnt), 1);
    reset = 0;
    settle();
    check("rst ost_cnt", 32'(ost_cnt), 0);
    check("rst err", 32'(err_rsp_orphan), 0);
    tick();
    reset = 1;
    m_if.rsp_valid = 1;
    settle();
    check("post-rst s0_rsp_valid", 32'(s0_if.rsp_valid), 0);
    tick();
    m_if.rsp_valid = 0;
    settle();
    check("post-rst err", 32'(err_rsp_orphan), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
